// File: rtl/led_seq_driver.sv
// led_seq_driver: lights one of NUM_LEDS outputs for a programmed time with
// PWM brightness and optional blink, then holds an all-off gap and pulses
// done. LED index order follows the game's colour order:
// 0 = red, 1 = blue, 2 = green, 3 = yellow.
module led_seq_driver #(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int TIME_W     = 16,
    parameter int BLINK_HALF = 1024,
    localparam int SEL_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SEL_W-1:0]    led_sel,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink,
    input  logic [TIME_W-1:0]   hold_cycles,
    input  logic [TIME_W-1:0]   gap_cycles,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done
);

    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;          // remaining cycles in SHOW/GAP minus one
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;      // 1 = visible half of the blink period
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                blink_q, blink_d;
    logic [TIME_W-1:0]   gap_q, gap_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                lit;

    // Next-state logic: capture on start, count SHOW then GAP down, abort overrides.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        sel_d       = sel_q;
        duty_d      = duty_q;
        blink_d     = blink_q;
        gap_d       = gap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    sel_d       = led_sel;
                    duty_d      = duty;
                    blink_d     = blink;
                    gap_d       = gap_cycles;
                    // A hold of 0 still shows for one cycle.
                    cnt_d       = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
                    state_d     = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
                if (cnt_q == '0) begin
                    if (gap_q != '0) begin
                        state_d = ST_GAP;
                        cnt_d   = gap_q - 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end
    end

    // State and operand registers, plus the free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sel_q       <= '0;
            duty_q      <= '0;
            blink_q     <= 1'b0;
            gap_q       <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
            duty_q      <= duty_d;
            blink_q     <= blink_d;
            gap_q       <= gap_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
        end
    end

    // Full-scale duty must stay on through the counter's top value as well.
    assign lit = (&duty_q) || (pwm_cnt_q < duty_q);

    // LED drive from registers only; an out-of-range select lights nothing.
    always_comb begin
        led = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led[i] = (state_q == ST_SHOW) && (sel_q == SEL_W'(i)) && lit
                     && (!blink_q || phase_q);
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = ((state_q == ST_SHOW) && (cnt_q == '0) && (gap_q == '0))
               || ((state_q == ST_GAP) && (cnt_q == '0));

endmodule

// File: tb/tb_led_seq_driver.sv
// Directed bench for led_seq_driver: a 4-LED build with a short blink period
// and a 3-LED build sharing the same stimulus for the out-of-range select.
module tb_led_seq_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] led_sel;
    logic [7:0] duty;
    logic       blink;
    logic [15:0] hold_cycles;
    logic [15:0] gap_cycles;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [2:0] led3;
    logic       busy3;
    logic       done3;

    int checks   = 0;
    int failures = 0;
    int on_cnt;
    int other_cnt;
    int done_cnt;
    int done_at;

    led_seq_driver #(.NUM_LEDS(4), .BLINK_HALF(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .led_sel(led_sel), .duty(duty), .blink(blink),
        .hold_cycles(hold_cycles), .gap_cycles(gap_cycles),
        .led(led), .busy(busy), .done(done)
    );

    led_seq_driver #(.NUM_LEDS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .led_sel(led_sel), .duty(duty), .blink(blink),
        .hold_cycles(hold_cycles), .gap_cycles(gap_cycles),
        .led(led3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [1:0] s, input logic [7:0] d, input logic b,
                         input logic [15:0] h, input logic [15:0] g);
        led_sel     = s;
        duty        = d;
        blink       = b;
        hold_cycles = h;
        gap_cycles  = g;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        setup(2'd0, 8'h00, 1'b0, 16'd0, 16'd0);
        #1;
        check("reset_led",  32'(led),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        #11 rst_n = 1'b1;
        step();

        // Reset mid-SHOW clears outputs without a clock edge.
        setup(2'd1, 8'hFF, 1'b0, 16'd20, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("midshow_led_before", 32'(led), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("midshow_rst_led",  32'(led),  32'h0);
        check("midshow_rst_busy", 32'(busy), 32'h0);
        check("midshow_rst_done", 32'(done), 32'h0);
        #1 rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            done_cnt += int'(done);
        end
        check("midshow_no_done", 32'(done_cnt), 32'd0);

        // Basic on/gap: 5 on, 3 off, done on busy-cycle 8.
        setup(2'd2, 8'hFF, 1'b0, 16'd5, 16'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("basic_led_c%0d", c),  32'(led),  (c <= 5) ? 32'h4 : 32'h0);
            check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'h1);
            check($sformatf("basic_done_c%0d", c), 32'(done), (c == 8) ? 32'h1 : 32'h0);
            step();
        end
        check("basic_busy_end", 32'(busy), 32'h0);
        check("basic_done_end", 32'(done), 32'h0);

        // PWM duty 64 over 512 cycles: 128 lit cycles.
        setup(2'd0, 8'd64, 1'b0, 16'd512, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        on_cnt = 0; other_cnt = 0; done_at = 0;
        for (int c = 1; c <= 512; c++) begin
            on_cnt    += int'(led[0]);
            other_cnt += int'(led[3:1] != 3'b000);
            if (done) done_at = c;
            step();
        end
        check("pwm64_on_count", 32'(on_cnt),    32'd128);
        check("pwm64_other",    32'(other_cnt), 32'd0);
        check("pwm64_done_at",  32'(done_at),   32'd512);
        check("pwm64_busy_end", 32'(busy),      32'h0);

        // Duty 0: never lit, done still pulses.
        setup(2'd0, 8'd0, 1'b0, 16'd512, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        on_cnt = 0; done_at = 0;
        for (int c = 1; c <= 512; c++) begin
            on_cnt += int'(led != 4'h0);
            if (done) done_at = c;
            step();
        end
        check("pwm0_on_count", 32'(on_cnt),  32'd0);
        check("pwm0_done_at",  32'(done_at), 32'd512);

        // Blink with half-period 4: on 4, off 4, on 4, off 4.
        setup(2'd1, 8'hFF, 1'b1, 16'd16, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("blink_led_c%0d", c), 32'(led),
                  (((c - 1) / 4) % 2 == 0) ? 32'h2 : 32'h0);
            check($sformatf("blink_done_c%0d", c), 32'(done), (c == 16) ? 32'h1 : 32'h0);
            step();
        end
        check("blink_busy_end", 32'(busy), 32'h0);

        // Start while busy is ignored and not queued.
        setup(2'd3, 8'hFF, 1'b0, 16'd4, 16'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin
                setup(2'd0, 8'hFF, 1'b0, 16'd1, 16'd0);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            check($sformatf("busystart_led_c%0d", c),  32'(led),  (c <= 4) ? 32'h8 : 32'h0);
            check($sformatf("busystart_done_c%0d", c), 32'(done), (c == 6) ? 32'h1 : 32'h0);
            step();
        end
        start = 1'b0;
        check("busystart_busy_end", 32'(busy), 32'h0);
        step();
        check("busystart_not_queued", 32'(busy), 32'h0);

        // Abort in cycle 3 of hold=10.
        setup(2'd0, 8'hFF, 1'b0, 16'd10, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort_led_c3", 32'(led), 32'h1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_led",  32'(led),  32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            done_cnt += int'(done) + int'(busy);
            step();
        end
        check("abort_quiet", 32'(done_cnt), 32'd0);

        // Start and abort together in IDLE: stays idle.
        setup(2'd2, 8'hFF, 1'b0, 16'd3, 16'd0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("race_busy", 32'(busy), 32'h0);
        check("race_led",  32'(led),  32'h0);
        step();
        check("race_busy_later", 32'(busy), 32'h0);

        // hold=0, gap=0: one busy cycle with done; then back-to-back start.
        setup(2'd3, 8'hFF, 1'b0, 16'd0, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_busy", 32'(busy), 32'h1);
        check("zero_done", 32'(done), 32'h1);
        check("zero_led",  32'(led),  32'h8);
        step();
        check("zero_idle_busy", 32'(busy), 32'h0);
        check("zero_idle_done", 32'(done), 32'h0);
        setup(2'd1, 8'hFF, 1'b0, 16'd2, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_busy",     32'(busy), 32'h1);
        check("b2b_led",      32'(led),  32'h2);
        check("b2b_done_c1",  32'(done), 32'h0);
        step();
        check("b2b_done_c2",  32'(done), 32'h1);
        step();
        check("b2b_busy_end", 32'(busy), 32'h0);

        // Out-of-range select on the 3-LED build: dark, but timing normal.
        setup(2'd3, 8'hFF, 1'b0, 16'd3, 16'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("oor_led3_c%0d", c),  32'(led3),  32'h0);
            check($sformatf("oor_busy3_c%0d", c), 32'(busy3), 32'h1);
            check($sformatf("oor_done3_c%0d", c), 32'(done3), (c == 4) ? 32'h1 : 32'h0);
            step();
        end
        check("oor_busy3_end", 32'(busy3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
